data_memory_bank: RTL
=====================

// Module: data_memory_bank
// PURPOSE
//  Parametrised single-port data memory for the MIPS datapath, successor to the fixed 64x16 store.
//  Adds byte-enable writes, a valid/ready request channel, a registered read response with backpressure,
//  and a sequential hardware clear: one word per cycle, run after reset or on request.
//  Sits between the MEM stage and storage; the stage stalls on req_ready=0.
// PARAMETERS
//  DATA_W  16            word width in bits; multiple of 8
//  ADDR_W  6             address width in bits
//  DEPTH   1<<ADDR_W     implemented words; 1..2**ADDR_W
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous, active-high reset
//  clear_start  in   1         pulse: zero whole array (ignored while busy)
//  busy         out  1         clear sequence in progress
//  req_valid    in   1         request present
//  req_ready    out  1         request accepted when valid&ready
//  req_we       in   1         1=write, 0=read
//  req_addr     in   ADDR_W    word address
//  req_be       in   DATA_W/8  byte enables (writes only); bit i -> byte i
//  req_wdata    in   DATA_W    write data
//  rsp_valid    out  1         read data valid; held until rsp_ready
//  rsp_ready    in   1         consumer accepts response
//  rsp_rdata    out  DATA_W    read data
//  rsp_err      out  1         read addressed >= DEPTH (rsp_rdata=0)
//  rsp_perr     out  1         parity mismatch on read (see CONFIGURATION)
// BEHAVIOUR
//  FSM states CLEAR, IDLE. rst asserted -> CLEAR, clr_cnt=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_perr=0.
//  Array contents are not reset by flops; they are zeroed by the CLEAR sequence.
//  CLEAR: each cycle write 0 (all bytes) to clr_cnt, increment; after writing DEPTH-1 -> IDLE, busy=0
//   on the next cycle. Total clear = DEPTH cycles. rst mid-clear restarts at word 0.
//  IDLE & clear_start -> CLEAR, clr_cnt=0. clear_start during CLEAR ignored.
//  clear_start & accepted request in the same cycle: clear wins; req_ready=0 that cycle.
//  req_ready = (state==IDLE) & !clear_start & (!rsp_valid | rsp_ready).
//  Write accepted: bytes with req_be[i]=1 updated at that clk edge; others kept; no response generated.
//   be=0 is a legal no-op. addr >= DEPTH: write dropped silently.
//  Read accepted at edge N: rsp_valid=1, rsp_rdata=mem[addr] from edge N (1-cycle latency).
//   addr >= DEPTH: rsp_rdata=0, rsp_err=1.
//  rsp_valid & !rsp_ready: rsp_* held stable, no new request accepted.
//  rsp_valid & rsp_ready & new read accepted: back-to-back, rsp_valid stays 1 with new data.
//  rsp_valid & rsp_ready & no read: rsp_valid->0 at next edge; rsp_rdata holds last value.
//  Read after write to the same address in a later cycle returns the new data; one op per cycle, so no collision.
//  Requests presented while busy stall; they are not lost.
// CONFIGURATION
//  MEM_PARITY_EN defined: one even-parity bit stored per byte, written with each enabled byte
//   (CLEAR writes parity 0). On read, any byte mismatch -> rsp_perr=1 alongside rsp_valid. Data returned as stored.
//  MEM_PARITY_EN undefined: no parity storage; rsp_perr tied 0.
// STRUCTURE
//  Package data_memory_pkg: state enum {CLEAR, IDLE}; function be_w(DATA_W)=DATA_W/8; parity helper.
//  Sub-module data_memory_array: storage, byte-enable write port, registered read (plus parity bits when enabled).
//  Top level holds the FSM, clear counter, handshake, range check and response register.
// TESTING
//  1 rst pulse, DEPTH=64 -> busy=1 for exactly 64 cycles, req_ready=0 throughout; read of any addr after that = 0x0000.
//  2 write addr 5 data 0xBEEF be=2'b11, then write addr 5 data 0x1234 be=2'b01 -> read addr 5 = 0xBE34, 1 cycle after accept.
//  3 read addr 7 with rsp_ready=0 for 3 cycles -> rsp held, req_ready=0; then ready=1 with back-to-back reads 8,9 -> one rsp per cycle.
//  4 DEPTH=48: read addr 50 -> rsp_err=1, rdata=0; write addr 50 then re-clear -> no array word changed.
//  5 clear_start while read pending in the same cycle -> clear wins, request stalls DEPTH cycles, then read returns 0.
//  6 rst asserted mid-clear (clr_cnt=20) -> restart from 0, busy for full DEPTH; with MEM_PARITY_EN, forced bit flip -> rsp_perr=1.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory bank.
package data_memory_pkg;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Even parity: stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Single-port storage with byte-enable writes and a registered read port.
// Optional per-byte even parity when MEM_PARITY_EN is defined.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic                        re,
    input  logic                        rzero,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [be_w(DATA_W)-1:0]     be,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rperr
);

    localparam int unsigned BE_W = be_w(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Out-of-range reads return zero; the register holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rzero ? '0 : mem[addr];
        end
    end

    assign rdata = rdata_q;

`ifdef MEM_PARITY_EN
    logic [BE_W-1:0] par [DEPTH];
    logic [BE_W-1:0] rd_calc;
    logic            rperr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    par[addr][i] <= byte_parity(wdata[8*i +: 8]);
                end
            end
        end
    end

    always_comb begin
        rd_calc = '0;
        for (int unsigned i = 0; i < BE_W; i++) begin
            rd_calc[i] = byte_parity(mem[addr][8*i +: 8]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rperr_q <= 1'b0;
        end else if (re) begin
            rperr_q <= !rzero && (rd_calc != par[addr]);
        end
    end

    assign rperr = rperr_q;
`else
    assign rperr = 1'b0;
`endif

endmodule

// File: rtl/data_memory_bank.sv
// MEM-stage data memory: request/response handshake, hardware clear sequence, range check.
// Define MEM_PARITY_EN to store and check per-byte parity.
module data_memory_bank
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_start,
    output logic                        busy,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [be_w(DATA_W)-1:0]     req_be,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_perr
);

    localparam int unsigned       BE_W      = be_w(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rsp_valid_q, rsp_err_q;
    logic              accept, rd_accept, in_range, rd_zero;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [BE_W-1:0]   arr_be;
    logic [DATA_W-1:0] arr_wdata;

    assign in_range = (32'(req_addr) < DEPTH);
    assign rd_zero  = !in_range;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = (state_q == StClear);
        req_ready = (state_q == StIdle) && !clear_start && (!rsp_valid_q || rsp_ready);
        accept    = req_valid && req_ready;
        rd_accept = accept && !req_we;
        arr_we    = 1'b0;
        arr_addr  = req_addr;
        arr_be    = req_be;
        arr_wdata = req_wdata;
        case (state_q)
            StClear: begin
                // The clear sweep owns the single port; requests stall meanwhile.
                arr_we    = 1'b1;
                arr_addr  = clr_cnt_q;
                arr_be    = '1;
                arr_wdata = '0;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (clear_start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end else begin
                    arr_we = accept && req_we && in_range;
                end
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Response is held while the consumer stalls; a read in the same cycle as a pop refills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (rd_accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rd_zero;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

    data_memory_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (arr_we),
        .re     (rd_accept),
        .rzero  (rd_zero),
        .addr   (arr_addr),
        .be     (arr_be),
        .wdata  (arr_wdata),
        .rdata  (rsp_rdata),
        .rperr  (rsp_perr)
    );

endmodule
